// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and byte-level helper functions.
// The S-box and its inverse are computed from GF(2^8) inversion, so no lookup tables are needed.
package aes_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    S_IDLE, S_KEYEXP, S_ROUND, S_OUT, S_DONE
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Byte b of a block lives at [127-8b -: 8]; b = 4*col + row.
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int b);
    return s[127-8*b -: 8];
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = get_byte(s, 4*((c + 4 - r) % 4) + r);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = inv_sbox(get_byte(s, b));
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4*c);
      a1 = get_byte(s, 4*c+1);
      a2 = get_byte(s, 4*c+2);
      a3 = get_byte(s, 4*c+3);
      o[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      o[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      o[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      o[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: next round key from the previous one and its Rcon byte.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] rk_in,
  input  logic [7:0]             rcon,
  output logic [AES_BLOCK_W-1:0] rk_out
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_rot, w_tmp;
  logic [31:0] w_o0, w_o1, w_o2, w_o3;

  assign {w_w0, w_w1, w_w2, w_w3} = rk_in;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_tmp = {sbox(w_rot[31:24]) ^ rcon, sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_o0  = w_w0 ^ w_tmp;
  assign w_o1  = w_w1 ^ w_o0;
  assign w_o2  = w_w2 ^ w_o1;
  assign w_o3  = w_w3 ^ w_o2;
  assign rk_out = {w_o0, w_o1, w_o2, w_o3};

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor, one inverse round per clock, with a cached 11-entry key schedule.
// Define AES_DEC_CBC_EN to add iv/iv_load ports and CBC unchaining of the output.
module aes_decrypt_core #(
  parameter int NR      = 10,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
  input  logic               key_load,
`ifdef AES_DEC_CBC_EN
  input  logic [BLOCK_W-1:0] iv,
  input  logic               iv_load,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);
  import aes_pkg::*;

  localparam logic [3:0] CNT_LAST = 4'(NR);

  state_e                    r_state, w_state_nxt;
  logic [NR:0][BLOCK_W-1:0]  r_rk;
  logic [BLOCK_W-1:0]        r_st, r_out;
  logic [3:0]                r_cnt;
  logic                      r_key_valid;
  logic                      w_accept, w_need_key;
  logic [BLOCK_W-1:0]        w_rk_prev, w_rk_next, w_rk_rnd, w_inv, w_mask;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_data   = r_out;
  assign w_accept   = in_valid && in_ready;
  assign w_need_key = key_load || !r_key_valid;

  always_comb begin
    w_rk_prev = '0;
    w_rk_rnd  = '0;
    for (int k = 0; k < NR; k++)
      if (r_cnt == 4'(k + 1)) w_rk_prev = r_rk[k];
    for (int k = 0; k <= NR; k++)
      if (r_cnt == 4'(k)) w_rk_rnd = r_rk[k];
  end

  aes_key_expand_step u_kexp (
    .rk_in  (w_rk_prev),
    .rcon   (rcon(r_cnt)),
    .rk_out (w_rk_next)
  );

  assign w_inv = inv_sub_bytes(inv_shift_rows(r_st)) ^ w_rk_rnd;

`ifdef AES_DEC_CBC_EN
  logic [BLOCK_W-1:0] r_mask, r_chain;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_chain <= '0;
    end else if (w_accept) begin
      r_mask  <= iv_load ? iv : r_chain;
      r_chain <= in_data;
    end
  end
  assign w_mask = r_mask;
`else
  assign w_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_need_key ? S_KEYEXP : S_ROUND;
      S_KEYEXP: if (r_cnt == CNT_LAST) w_state_nxt = S_ROUND;
      S_ROUND:  if (r_cnt == 4'd0) w_state_nxt = S_OUT;
      S_OUT:    w_state_nxt = S_DONE;
      S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk        <= '0;
      r_st        <= '0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_key_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_need_key) begin
            r_rk[0]     <= in_key;
            r_st        <= in_data;
            r_cnt       <= 4'd1;
            r_key_valid <= 1'b0;
          end else begin
            r_st  <= in_data ^ r_rk[NR];
            r_cnt <= CNT_LAST - 4'd1;
          end
        end
        S_KEYEXP: begin
          for (int k = 1; k <= NR; k++)
            if (r_cnt == 4'(k)) r_rk[k] <= w_rk_next;
          // The last key step also performs the initial AddRoundKey with rk[NR].
          if (r_cnt == CNT_LAST) begin
            r_key_valid <= 1'b1;
            r_st        <= r_st ^ w_rk_next;
            r_cnt       <= CNT_LAST - 4'd1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ROUND: begin
          if (r_cnt == 4'd0) begin
            r_st <= w_inv;
          end else begin
            r_st  <= inv_mix_columns(w_inv);
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // Plaintext lands in its own register so out_data survives the next block.
        S_OUT: r_out <= r_st ^ w_mask;
        default: ;
      endcase
    end
  end

endmodule
